// File: rtl/tone_gen_pkg.sv
// Shared types and constants for the tone generator and the button-to-note mapper.
package tone_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        HOLD
    } state_t;

    localparam int unsigned DEF_FREQ_W = 29;
    localparam int unsigned MIN_HALF   = 2;

    // Half-period words in CLK cycles at 100 MHz
    localparam int unsigned NOTE_C = 191112;
    localparam int unsigned NOTE_D = 170262;
    localparam int unsigned NOTE_E = 151686;
    localparam int unsigned NOTE_G = 127551;

endpackage

// File: rtl/tone_divider.sv
// Half-period divider: counts CLK cycles and flags the last cycle of each half-period.
module tone_divider
    import tone_gen_pkg::*;
#(
    parameter int unsigned FREQ_W = DEF_FREQ_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              clear,
    input  logic              load,
    input  logic [FREQ_W-1:0] load_val,
    output logic              boundary
);

    logic [FREQ_W-1:0] cnt;
    logic [FREQ_W-1:0] period;

    assign boundary = (period != '0) && (cnt == period - 1'b1);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt    <= '0;
            period <= '0;
        end else if (clear) begin
            cnt    <= '0;
            period <= '0;
        end else if (load) begin
            cnt    <= '0;
            period <= load_val;
        end else if (boundary) begin
            cnt    <= '0;
        end else if (period != '0) begin
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tone_generator.sv
// Square-wave speaker driver with glitch-free pitch changes and a note-start counter.
// Optional release tail enabled by defining TONE_GEN_HOLD_EN.
module tone_generator
    import tone_gen_pkg::*;
#(
    parameter int unsigned FREQ_W      = DEF_FREQ_W,
    parameter int unsigned HOLD_CYCLES = 5_000_000,
    parameter int unsigned NOTE_W      = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [FREQ_W-1:0] FREQUENCY,
    output logic              AUDIO,
    output logic              AUD_SD,
    output logic              PLAYING,
    output logic [NOTE_W-1:0] NOTES
);

    state_t            state, state_n;
    logic [FREQ_W-1:0] freq_q;
    logic              audio_q, audio_n;
    logic [NOTE_W-1:0] notes_q;
    logic              div_clear, div_load, note_inc, boundary;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            freq_q <= '0;
        end else if (FREQUENCY == FREQ_W'(1)) begin
            freq_q <= FREQ_W'(MIN_HALF);
        end else begin
            freq_q <= FREQUENCY;
        end
    end

    tone_divider #(
        .FREQ_W (FREQ_W)
    ) u_div (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .clear    (div_clear),
        .load     (div_load),
        .load_val (freq_q),
        .boundary (boundary)
    );

`ifdef TONE_GEN_HOLD_EN
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_done;

    assign hold_done = (hold_cnt == HOLD_W'(HOLD_CYCLES));

    always_ff @(posedge CLK) begin
        if (!RST_N || state != HOLD) begin
            hold_cnt <= '0;
        end else if (!hold_done) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        state_n   = state;
        audio_n   = audio_q;
        div_clear = 1'b0;
        div_load  = 1'b0;
        note_inc  = 1'b0;
        case (state)
            IDLE: begin
                audio_n   = 1'b0;
                div_clear = 1'b1;
                if (freq_q != '0) begin
                    state_n   = PLAY;
                    audio_n   = 1'b1;
                    div_clear = 1'b0;
                    div_load  = 1'b1;
                    note_inc  = 1'b1;
                end
            end
            PLAY: begin
                if (boundary) begin
                    if (freq_q != '0) begin
                        audio_n  = ~audio_q;
                        div_load = 1'b1;
                    end else begin
`ifdef TONE_GEN_HOLD_EN
                        // Divider keeps the last period; it self-restarts at the boundary
                        state_n = HOLD;
                        audio_n = ~audio_q;
`else
                        state_n   = IDLE;
                        audio_n   = 1'b0;
                        div_clear = 1'b1;
`endif
                    end
                end
            end
            HOLD: begin
`ifdef TONE_GEN_HOLD_EN
                if (boundary) begin
                    if (freq_q != '0) begin
                        state_n  = PLAY;
                        audio_n  = ~audio_q;
                        div_load = 1'b1;
                    end else if (hold_done) begin
                        state_n   = IDLE;
                        audio_n   = 1'b0;
                        div_clear = 1'b1;
                    end else begin
                        audio_n = ~audio_q;
                    end
                end
`else
                state_n   = IDLE;
                audio_n   = 1'b0;
                div_clear = 1'b1;
`endif
            end
            default: begin
                state_n   = IDLE;
                audio_n   = 1'b0;
                div_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= IDLE;
            audio_q <= 1'b0;
            notes_q <= '0;
        end else begin
            state   <= state_n;
            audio_q <= audio_n;
            if (note_inc && notes_q != '1) begin
                notes_q <= notes_q + 1'b1;
            end
        end
    end

    assign AUDIO   = audio_q;
    assign AUD_SD  = (state != IDLE);
    assign PLAYING = (state == PLAY);
    assign NOTES   = notes_q;

endmodule

// File: tb/tb_tone_generator.sv
// Self-checking bench for tone_generator: half-period model plus directed literal checks.
// Covers the TONE_GEN_HOLD_EN build when that macro is defined.
module tb_tone_generator;

    localparam int unsigned FW   = 29;
    localparam int unsigned HC   = 20;
    localparam int unsigned NW   = 4;
    localparam int unsigned NMAX = (1 << NW) - 1;
`ifdef TONE_GEN_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST_N;
    logic [FW-1:0] FREQUENCY;
    logic          AUDIO, AUD_SD, PLAYING;
    logic [NW-1:0] NOTES;

    int tests = 0;
    int fails = 0;
    int step  = 0;
    bit chk_en = 1'b0;

    tone_generator #(
        .FREQ_W      (FW),
        .HOLD_CYCLES (HC),
        .NOTE_W      (NW)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .FREQUENCY (FREQUENCY),
        .AUDIO     (AUDIO),
        .AUD_SD    (AUD_SD),
        .PLAYING   (PLAYING),
        .NOTES     (NOTES)
    );

    always #5 CLK = ~CLK;

    // Model: tracks cycles left in the current half-period rather than a counter
    int unsigned m_fq = 0, m_left = 0, m_cur = 0, m_notes = 0, m_hcnt = 0;
    bit          m_active = 0, m_hold = 0, m_level = 0;

    always @(posedge CLK) begin
        int unsigned fnew, ohc;
        bit          oh;
        fnew = (FREQUENCY == 1) ? 2 : FREQUENCY;
        if (!RST_N) begin
            m_fq = 0; m_left = 0; m_cur = 0; m_notes = 0; m_hcnt = 0;
            m_active = 0; m_hold = 0; m_level = 0;
        end else begin
            oh  = m_hold;
            ohc = m_hcnt;
            m_hcnt = oh ? ((ohc < HC) ? ohc + 1 : ohc) : 0;
            if (!m_active) begin
                if (m_fq != 0) begin
                    m_active = 1; m_level = 1; m_left = m_fq; m_cur = m_fq;
                    if (m_notes < NMAX) m_notes++;
                end
            end else if (m_left == 1) begin
                if (m_fq != 0) begin
                    m_level = !m_level; m_left = m_fq; m_cur = m_fq; m_hold = 0;
                end else if (HOLD_EN && (!oh || ohc < HC)) begin
                    m_hold = 1; m_level = !m_level; m_left = m_cur;
                end else begin
                    m_active = 0; m_hold = 0; m_level = 0;
                end
            end else begin
                m_left--;
            end
            m_fq = fnew;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            tests += 4;
            if (AUDIO !== m_level) begin
                fails++;
                $display("FAIL model_AUDIO t=%0t got %b exp %b", $time, AUDIO, m_level);
            end
            if (AUD_SD !== m_active) begin
                fails++;
                $display("FAIL model_AUD_SD t=%0t got %b exp %b", $time, AUD_SD, m_active);
            end
            if (PLAYING !== (m_active && !m_hold)) begin
                fails++;
                $display("FAIL model_PLAYING t=%0t got %b exp %b", $time, PLAYING, m_active && !m_hold);
            end
            if (NOTES !== NW'(m_notes)) begin
                fails++;
                $display("FAIL model_NOTES t=%0t got %0d exp %0d", $time, NOTES, m_notes);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step=%0d got %0h exp %0h", name, step, act, exp);
        end
    endtask

    task automatic goto(input int k);
        while (step < k) begin
            @(negedge CLK);
            step++;
        end
    endtask

    initial begin
        RST_N     = 1'b0;
        FREQUENCY = '0;
        repeat (3) @(negedge CLK);
        chk_en = 1'b1;
        check("rst_AUDIO", 32'(AUDIO), 0);
        check("rst_AUD_SD", 32'(AUD_SD), 0);
        check("rst_PLAYING", 32'(PLAYING), 0);
        check("rst_NOTES", 32'(NOTES), 0);
        RST_N = 1'b1;
        step  = 0;
`ifndef TONE_GEN_HOLD_EN
        FREQUENCY = 4;
        goto(1);  check("start_not_yet", 32'(AUDIO), 0);
        goto(2);  check("start_AUDIO", 32'(AUDIO), 1);
                  check("start_PLAYING", 32'(PLAYING), 1);
                  check("start_AUD_SD", 32'(AUD_SD), 1);
                  check("start_NOTES", 32'(NOTES), 1);
        goto(5);  check("p4_high_last", 32'(AUDIO), 1);
        goto(6);  check("p4_toggle", 32'(AUDIO), 0);
        goto(7);  FREQUENCY = 6;
        goto(9);  check("chg_old_half", 32'(AUDIO), 0);
        goto(10); check("chg_boundary", 32'(AUDIO), 1);
        goto(15); check("p6_high_last", 32'(AUDIO), 1);
        goto(16); check("p6_toggle", 32'(AUDIO), 0);
        FREQUENCY = 1;
        goto(22); check("clamp_a", 32'(AUDIO), 1);
        goto(24); check("clamp_b", 32'(AUDIO), 0);
        goto(26); check("clamp_c", 32'(AUDIO), 1);
        goto(27); FREQUENCY = 5;
        goto(30); check("p5_high", 32'(AUDIO), 1);
        goto(32); FREQUENCY = 0;
        goto(34); check("rel_completes", 32'(AUDIO), 1);
                  check("rel_sd_on", 32'(AUD_SD), 1);
        goto(35); check("rel_AUDIO", 32'(AUDIO), 0);
                  check("rel_AUD_SD", 32'(AUD_SD), 0);
                  check("rel_PLAYING", 32'(PLAYING), 0);
        goto(36); FREQUENCY = 5;
        goto(38); check("note2_AUDIO", 32'(AUDIO), 1);
                  check("note2_NOTES", 32'(NOTES), 2);
        goto(40); FREQUENCY = 0;
        goto(42); FREQUENCY = 3;
        goto(43); check("race_idle_wins", 32'(AUD_SD), 0);
        goto(44); check("race_new_note", 32'(AUDIO), 1);
                  check("race_NOTES", 32'(NOTES), 3);
        goto(46); RST_N = 1'b0;
        goto(47); check("midrst_AUDIO", 32'(AUDIO), 0);
                  check("midrst_AUD_SD", 32'(AUD_SD), 0);
                  check("midrst_PLAYING", 32'(PLAYING), 0);
                  check("midrst_NOTES", 32'(NOTES), 0);
                  RST_N = 1'b1;
        goto(49); check("post_rst_NOTES", 32'(NOTES), 1);
        FREQUENCY = 0;
        goto(57);
        for (int i = 0; i < 20; i++) begin
            FREQUENCY = 2;
            goto(step + 3);
            FREQUENCY = 0;
            goto(step + 5);
            check("sat_NOTES", 32'(NOTES), (i + 2 > 15) ? 15 : i + 2);
        end
        check("sat_final", 32'(NOTES), 32'hF);
`else
        FREQUENCY = 3;
        goto(2);  check("h_start", 32'(AUDIO), 1);
        goto(6);  FREQUENCY = 0;
        goto(10); check("h_PLAYING", 32'(PLAYING), 0);
                  check("h_AUD_SD", 32'(AUD_SD), 1);
        goto(40); check("h_silent_sd", 32'(AUD_SD), 0);
                  check("h_silent_audio", 32'(AUDIO), 0);
        goto(41); FREQUENCY = 3;
        goto(45); check("h_note2", 32'(NOTES), 2);
        goto(50); FREQUENCY = 0;
        goto(60); check("h_in_hold", 32'(PLAYING), 0);
                  FREQUENCY = 3;
        goto(70); check("h_back_play", 32'(PLAYING), 1);
                  check("h_notes_kept", 32'(NOTES), 2);
`endif
        goto(step + 2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
